// File: rtl/proc_pkg.sv
// Shared definitions for the proc instruction issuer: opcodes, issuer state
// encoding and the default halt sentinel.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_FETCH_IMM,
    S_LOAD_IMM,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_NEXT,
    S_HALT,
    S_ERROR
  } issuer_state_t;

  function automatic logic is_mvi(input logic [2:0] op);
    return op == OP_MVI;
  endfunction

endpackage

// File: rtl/issue_timer.sv
// Wait-for-Done watchdog: cleared on issue, counts WAIT cycles, and flags the
// last permitted WAIT cycle so the issuer can leave for ERROR on that edge.
module issue_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of WAIT cycles already completed
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/proc_issuer.sv
// Fetches instruction words from a 1-cycle-latency ROM and drives them onto
// the processor DIN/Run/Done handshake, prefetching the mvi immediate.
module proc_issuer
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        RetireCount
);

  issuer_state_t     state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   pc_adv;
  logic [DATA_W-1:0] instr_q, imm_q;
  logic [7:0]        retire_q;
  logic              ld_mvi, cur_mvi, idle_like, done_ok, timer_expired;

  assign ld_mvi    = is_mvi(MemData[8:6]);
  assign cur_mvi   = is_mvi(instr_q[8:6]);
  assign idle_like = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);
  assign done_ok   = Done && ((state == S_IMM) || (state == S_WAIT));
  // carry out of the ADDR_W-bit advance marks the end of program space
  assign pc_adv    = {1'b0, pc} + (ADDR_W + 1)'(cur_mvi ? 2 : 1);

  issue_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .clear   (state == S_ISSUE),
    .enable  (state == S_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT, S_ERROR: if (Start) state_nxt = S_FETCH;
      S_FETCH:                 state_nxt = S_LOAD;
      S_LOAD: begin
        if (MemData == HALT_WORD)  state_nxt = S_HALT;
        else if (ld_mvi && (&pc))  state_nxt = S_ERROR;
        else if (ld_mvi)           state_nxt = S_FETCH_IMM;
        else                       state_nxt = S_ISSUE;
      end
      S_FETCH_IMM:             state_nxt = S_LOAD_IMM;
      S_LOAD_IMM:              state_nxt = S_ISSUE;
      S_ISSUE:                 state_nxt = cur_mvi ? S_IMM : S_WAIT;
      S_IMM:                   state_nxt = Done ? S_NEXT : S_WAIT;
      S_WAIT: begin
        if (Done)               state_nxt = S_NEXT;
        else if (timer_expired) state_nxt = S_ERROR;
      end
      S_NEXT:                  state_nxt = pc_adv[ADDR_W] ? S_HALT : S_FETCH;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pc       <= '0;
      retire_q <= '0;
    end else begin
      if (idle_like && Start) begin
        pc       <= '0;
        retire_q <= '0;
      end
      if (state == S_NEXT) pc <= pc_adv[ADDR_W-1:0];
      if (done_ok) retire_q <= retire_q + 8'd1;
    end
  end

  // instruction holding registers need no reset: DIN only shows them when issuing
  always_ff @(posedge Clock) begin
    if (state == S_LOAD)     instr_q <= MemData;
    if (state == S_LOAD_IMM) imm_q   <= MemData;
  end

  always_comb begin
    MemAddr = pc;
    DIN     = '0;
    Run     = 1'b0;
    case (state)
      S_FETCH_IMM: MemAddr = pc + ADDR_W'(1);
      S_ISSUE: begin
        DIN = instr_q;
        Run = 1'b1;
      end
      S_IMM: begin
        DIN = imm_q;
        Run = 1'b1;
      end
      S_WAIT:      Run = 1'b1;
      default:     ;
    endcase
    Busy   = !idle_like;
    Halted = (state == S_HALT);
    Error  = (state == S_ERROR);
  end

  assign RetireCount = retire_q;

endmodule
